regfile_wb_ctrl: RTL

Writer-side controller for the register file. It merges two writeback sources into the register file's single write port (wen/waddr/din):
- Source A: the in-order pipeline. It has priority and is never back-pressured.
- Source B: a long-latency unit (load/muldiv). It uses a valid/ready handshake and is buffered in a FIFO.

It also keeps a pending-write scoreboard so decode can stall on RAW hazards against outstanding B results.

---
 rtl/regfile_wb_ctrl_pkg.sv | 26 ++
 rtl/regfile_wb_ctrl_if.sv | 38 +++
 rtl/regfile_wb_ctrl_wb_fifo.sv | 45 ++++
 rtl/regfile_wb_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared core widths (register/data ranges, writeback FIFO depth) and the types used by regfile_wb_ctrl.
// Optional macro WB_BYPASS_EN is consumed by the top module, not here.
`ifndef VERIRISCV_CORE_VH
`define VERIRISCV_CORE_VH
`define RF_RANGE 4:0
`define DATA_RANGE 31:0
`define REG_NUM 32
`define WB_FIFO_DEPTH 4
`endif

package regfile_wb_ctrl_pkg;

  localparam int REG_NUM = `REG_NUM;

  typedef struct packed {
    logic [`RF_RANGE]   rd;
    logic [`DATA_RANGE] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  function automatic logic is_x0(input logic [`RF_RANGE] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bus bundle for the writeback controller: both writeback sources, decode scoreboard
// and bypass lookups, and the register file write port.
interface regfile_wb_ctrl_if;
  logic               a_valid;
  logic [`RF_RANGE]   a_rd;
  logic [`DATA_RANGE] a_data;
  logic               b_valid;
  logic               b_ready;
  logic [`RF_RANGE]   b_rd;
  logic [`DATA_RANGE] b_data;
  logic               iss_valid;
  logic [`RF_RANGE]   iss_rd;
  logic [`RF_RANGE]   chk_rs1;
  logic [`RF_RANGE]   chk_rs2;
  logic               busy_rs1;
  logic               busy_rs2;
  logic               rf_wen;
  logic [`RF_RANGE]   rf_waddr;
  logic [`DATA_RANGE] rf_din;
  logic               byp_rs1_hit;
  logic               byp_rs2_hit;
  logic [`DATA_RANGE] byp_rs1_data;
  logic [`DATA_RANGE] byp_rs2_data;

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  iss_valid, iss_rd, chk_rs1, chk_rs2,
    output b_ready, busy_rs1, busy_rs2, rf_wen, rf_waddr, rf_din,
    output byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data
  );

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output iss_valid, iss_rd, chk_rs1, chk_rs2,
    input  b_ready, busy_rs1, busy_rs2, rf_wen, rf_waddr, rf_din,
    input  byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data
  );
endinterface

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// Synchronous FIFO buffering long-latency writeback results ({rd,data}).
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
module regfile_wb_ctrl_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register file writeback arbiter: pipeline writes win, buffered long-latency results fill idle slots,
// and a pending-write scoreboard flags RAW hazards. Optional macro WB_BYPASS_EN enables the bypass outputs.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = `WB_FIFO_DEPTH
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_ctrl_if.slave bus
);
  wb_entry_t          push_entry;
  wb_entry_t          head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [REG_NUM-1:0] pending;
  logic [REG_NUM-1:0] pending_nxt;
  logic               rf_wen;
  logic [`RF_RANGE]   rf_waddr;
  logic [`DATA_RANGE] rf_din;

  assign push_entry  = '{rd: bus.b_rd, data: bus.b_data};
  assign push        = bus.b_valid && !full;
  assign pop         = !bus.a_valid && !empty;
  assign bus.b_ready = !full;

  regfile_wb_ctrl_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // x0 writes are still consumed so the FIFO keeps draining; only the enable is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_din   <= '0;
    end else if (bus.a_valid) begin
      rf_wen   <= !is_x0(bus.a_rd);
      rf_waddr <= bus.a_rd;
      rf_din   <= bus.a_data;
    end else if (pop) begin
      rf_wen   <= !is_x0(head.rd);
      rf_waddr <= head.rd;
      rf_din   <= head.data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // Issue is applied after the pop clear so a same-cycle set wins.
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head.rd] = 1'b0;
    if (bus.iss_valid) pending_nxt[bus.iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign bus.busy_rs1 = pending[bus.chk_rs1];
  assign bus.busy_rs2 = pending[bus.chk_rs2];
  assign bus.rf_wen   = rf_wen;
  assign bus.rf_waddr = rf_waddr;
  assign bus.rf_din   = rf_din;

`ifdef WB_BYPASS_EN
  assign bus.byp_rs1_hit  = rf_wen && (rf_waddr == bus.chk_rs1) && !is_x0(bus.chk_rs1);
  assign bus.byp_rs2_hit  = rf_wen && (rf_waddr == bus.chk_rs2) && !is_x0(bus.chk_rs2);
  assign bus.byp_rs1_data = rf_din;
  assign bus.byp_rs2_data = rf_din;
`else
  assign bus.byp_rs1_hit  = 1'b0;
  assign bus.byp_rs2_hit  = 1'b0;
  assign bus.byp_rs1_data = '0;
  assign bus.byp_rs2_data = '0;
`endif

  // Protocol checks: decode must stall WAW, and each source must agree with the scoreboard.
  a_iss_waw: assert property (@(posedge clk) disable iff (rst)
    (bus.iss_valid && !is_x0(bus.iss_rd)) |-> (!pending[bus.iss_rd] || (pop && head.rd == bus.iss_rd)));
  a_src_a_pending: assert property (@(posedge clk) disable iff (rst)
    (bus.a_valid && !is_x0(bus.a_rd)) |-> !pending[bus.a_rd]);
  a_src_b_unissued: assert property (@(posedge clk) disable iff (rst)
    (push && !is_x0(bus.b_rd)) |-> pending[bus.b_rd]);

endmodule
